// File: rtl/mix_frame_serializer.sv
// mix_frame_serializer: captures eight mixer words and streams them out with signature, frame and drop counters
module mix_frame_serializer #(
  parameter int DROP_W = 16,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap_strobe,
  input  logic [255:0]       in_words,
  output logic [31:0]        out_data,
  output logic [2:0]         out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [31:0]        signature,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [DROP_W-1:0]  drop_cnt,
  output logic               frame_done
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [255:0] act, pend;
  logic pend_v;
  logic [2:0] idx;
  logic hs, fin;
  assign out_valid = state == SEND;
  assign out_data = out_valid ? act[{idx, 5'b0} +: 32] : '0;
  assign out_idx = idx;
  assign out_last = out_valid && idx == 3'd7;
  assign hs = out_valid && out_ready;
  assign fin = hs && idx == 3'd7;
  always_comb begin
    state_nx = state == IDLE ? (cap_strobe ? SEND : IDLE)
                             : (fin && !pend_v && !cap_strobe ? IDLE : SEND);
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      pend_v <= 1'b0;
      signature <= '0;
      frame_cnt <= '0;
      drop_cnt <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= fin;
      if (state == IDLE && cap_strobe) begin
        act <= in_words;
        idx <= '0;
      end
      if (hs) begin
        signature <= {signature[26:0], signature[31:27]} + (out_data ^ {29'b0, idx});
        idx <= idx + 3'd1;
      end
      // the word-7 handshake reloads act; a capture elsewhere in SEND goes to the pending slot or is dropped
      if (fin) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (pend_v) begin
          act <= pend;
          if (cap_strobe) pend <= in_words;
          else pend_v <= 1'b0;
        end else if (cap_strobe) begin
          act <= in_words;
        end
      end else if (state == SEND && cap_strobe) begin
        if (!pend_v) begin
          pend <= in_words;
          pend_v <= 1'b1;
        end else if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mix_frame_serializer.sv
// tb_mix_frame_serializer: table vectors, corner sequences and random traffic against a transaction-level model
module tb_mix_frame_serializer;
  logic clk = 0;
  logic rst, cap_strobe, out_ready;
  logic [255:0] in_words;
  logic [31:0] out_data, signature;
  logic [2:0] out_idx;
  logic out_valid, out_last, frame_done;
  logic [15:0] frame_cnt;
  logic [1:0] drop_cnt;

  mix_frame_serializer #(.DROP_W(2), .FRAME_W(16)) dut (
    .clk(clk), .rst(rst), .cap_strobe(cap_strobe), .in_words(in_words),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .signature(signature),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  bit armed = 0;

  bit m_busy, m_done;
  int m_pos, m_drops;
  logic [31:0] m_cur [8];
  logic [255:0] pend_q [$];
  logic [31:0] m_sig;
  logic [15:0] m_frames;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [31:0] rotl5(input logic [31:0] s);
    return (s << 5) | (s >> 27);
  endfunction

  function automatic logic [31:0] golden(input logic [255:0] w, input logic [31:0] s0);
    logic [31:0] s = s0;
    for (int k = 0; k < 8; k++) s = rotl5(s) + (w[32*k +: 32] ^ k);
    return s;
  endfunction

  function automatic logic [255:0] rnd_words();
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[32*k +: 32] = $urandom;
    return w;
  endfunction

  task automatic load(input logic [255:0] w);
    for (int k = 0; k < 8; k++) m_cur[k] = w[32*k +: 32];
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_pos = 0; m_drops = 0;
    m_sig = 0; m_frames = 0;
    pend_q.delete();
  endtask

  task automatic model_edge(input bit r, input bit c, input logic [255:0] w, input bit rd);
    bit h, f;
    if (r) begin
      model_reset();
      return;
    end
    h = m_busy && rd;
    f = h && m_pos == 7;
    m_done = f;
    if (h) m_sig = rotl5(m_sig) + (m_cur[m_pos] ^ m_pos);
    if (f) begin
      m_frames++;
      m_pos = 0;
      if (pend_q.size() != 0) begin
        load(pend_q.pop_front());
        if (c) pend_q.push_back(w);
      end else if (c) load(w);
      else m_busy = 0;
    end else begin
      if (h) m_pos++;
      if (c) begin
        if (!m_busy) begin
          load(w);
          m_busy = 1;
          m_pos = 0;
        end else if (pend_q.size() == 0) pend_q.push_back(w);
        else if (m_drops < 3) m_drops++;
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input logic [255:0] w, input bit rd);
    rst = r; cap_strobe = c; in_words = w; out_ready = rd;
    if (armed) begin
      chk("out_valid", 32'(out_valid), 32'(m_busy));
      chk("out_data", out_data, m_busy ? m_cur[m_pos] : 32'h0);
      chk("out_idx", 32'(out_idx), 32'(m_pos));
      chk("out_last", 32'(out_last), 32'(m_busy && m_pos == 7));
      chk("signature", signature, m_sig);
      chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
      chk("frame_done", 32'(frame_done), 32'(m_done));
    end
    @(posedge clk);
    model_edge(r, c, w, rd);
    #1;
  endtask

  typedef struct {
    bit cap, rdy;
    bit ev, el, ed;
    int ei;
  } vec_t;

  initial begin
    vec_t tbl [11];
    logic [255:0] w07, wa, wb, wc;
    int hs, cnt;
    for (int k = 0; k < 8; k++) w07[32*k +: 32] = k;
    tbl[0] = '{cap: 1, rdy: 1, ev: 0, el: 0, ed: 0, ei: 0};
    for (int i = 1; i <= 8; i++) tbl[i] = '{cap: 0, rdy: 1, ev: 1, el: i == 8, ed: 0, ei: i - 1};
    tbl[9] = '{cap: 0, rdy: 1, ev: 0, el: 0, ed: 1, ei: 0};
    tbl[10] = '{cap: 0, rdy: 1, ev: 0, el: 0, ed: 0, ei: 0};

    step(1, 1, w07, 1);
    armed = 1;
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_frame_cnt", 32'(frame_cnt), 0);

    // first frame: words 0..7, ready held high
    for (int i = 0; i < 11; i++) begin
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].ev));
      chk("tbl_last", 32'(out_last), 32'(tbl[i].el));
      chk("tbl_done", 32'(frame_done), 32'(tbl[i].ed));
      if (tbl[i].ev) begin
        chk("tbl_idx", 32'(out_idx), 32'(tbl[i].ei));
        chk("tbl_data", out_data, 32'(tbl[i].ei));
      end
      if (i == 2) chk("tbl_sig_w1", signature, 32'h0);
      if (i == 9) begin
        chk("tbl_frame_cnt", 32'(frame_cnt), 1);
        chk("tbl_sig", signature, golden(w07, 0));
      end
      step(0, tbl[i].cap, w07, tbl[i].rdy);
    end

    // stalled frame with ready pattern 1,0,0,1
    step(1, 0, '0, 0);
    step(0, 1, w07, 0);
    hs = 0;
    for (int i = 0; i < 64 && !frame_done; i++) begin
      bit rd = (i % 3) == 0;
      hs += int'(out_valid && rd);
      step(0, 0, '0, rd);
    end
    chk("stall_done", 32'(frame_done), 1);
    chk("stall_handshakes", hs, 8);
    chk("stall_sig", signature, golden(w07, 0));

    // A active, B pends, C dropped
    step(1, 0, '0, 0);
    wa = rnd_words(); wb = rnd_words(); wc = rnd_words();
    step(0, 1, wa, 1);
    cnt = 0;
    for (int i = 0; i < 18; i++) begin
      cnt += int'(out_valid);
      step(0, i == 0 || i == 2, i == 0 ? wb : wc, 1);
    end
    chk("abc_valid_cycles", cnt, 16);
    chk("abc_frame_cnt", 32'(frame_cnt), 2);
    chk("abc_drop_cnt", 32'(drop_cnt), 1);
    chk("abc_sig", signature, golden(wb, golden(wa, 0)));

    // capture exactly on the word-7 handshake
    step(1, 0, '0, 0);
    step(0, 1, wa, 1);
    repeat (7) step(0, 0, '0, 1);
    step(0, 1, wb, 1);
    chk("w7_valid", 32'(out_valid), 1);
    chk("w7_idx", 32'(out_idx), 0);
    chk("w7_data", out_data, wb[31:0]);
    step(0, 1, wc, 1);
    chk("w7_no_drop", 32'(drop_cnt), 0);
    repeat (16) step(0, 0, '0, 1);
    chk("w7_frame_cnt", 32'(frame_cnt), 3);

    // drop counter saturation
    step(1, 0, '0, 0);
    step(0, 1, wa, 0);
    repeat (6) step(0, 1, rnd_words(), 0);
    chk("sat_drop_cnt", 32'(drop_cnt), 3);
    repeat (3) step(0, 1, rnd_words(), 0);
    chk("sat_drop_hold", 32'(drop_cnt), 3);

    // reset mid-frame with a pending capture
    step(1, 0, '0, 0);
    step(0, 1, wa, 1);
    step(0, 1, wb, 1);
    repeat (3) step(0, 0, '0, 1);
    chk("midrst_idx", 32'(out_idx), 4);
    step(1, 1, wc, 1);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_sig", signature, 0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 0);
    step(0, 1, wc, 1);
    chk("midrst_restart_idx", 32'(out_idx), 0);
    chk("midrst_restart_data", out_data, wc[31:0]);
    repeat (9) step(0, 0, '0, 1);
    chk("midrst_one_frame", 32'(frame_cnt), 1);
    chk("midrst_idle", 32'(out_valid), 0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, rnd_words(), $urandom_range(0, 2) != 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mix_frame_serializer.md
# mix_frame_serializer

Downstream stage of the eight-lane 32-bit mixing core. It captures all eight state words when the core signals an update, then streams them out one word per handshake over a 32-bit valid/ready port. Along the way it keeps a running 32-bit signature and frame and drop counters, so long simulation runs can be checked by comparing one word. A single pending slot absorbs one capture that arrives while a frame is still draining.

## Interface
Parameters:
- DROP_W, 16, width of the saturating dropped-capture counter
- FRAME_W, 16, width of the wrapping completed-frame counter

Ports:
- clk  in  1  sole clock; all state updates on posedge clk
- rst  in  1  reset, synchronous, active-high
- cap_strobe  in  1  one-cycle pulse: the mixer's eight words are valid this cycle
- in_words  in  256  captured state; word k = in_words[32k+31:32k], k=0..7 (o0 in bits 31:0)
- out_data  out  32  current word of the frame being sent
- out_idx  out  3  index of out_data within the frame
- out_valid  out  1  out_data/out_idx/out_last valid
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- out_last  out  1  high with word index 7
- signature  out  32  running signature over all accepted words
- frame_cnt  out  FRAME_W  completed frames, wraps
- drop_cnt  out  DROP_W  captures discarded, saturates at all-ones
- frame_done  out  1  one-cycle pulse, the cycle after word 7 is accepted

## Operation
- Storage: active buffer act[0..7] plus one pending slot pend[0..7] with flag pend_v.
- FSM: IDLE, SEND.
- IDLE: out_valid=0. If cap_strobe, then act<=in_words, idx<=0, go to SEND.
- SEND: out_valid=1, out_data=act[idx], out_last=(idx==7). On handshake: signature<={signature[26:0],signature[31:27]} + (out_data ^ {29'b0,idx}), mod 2^32.
  - Handshake with idx<7: idx<=idx+1.
  - Handshake with idx==7: frame_cnt++, frame_done pulse next cycle, idx<=0. Next-frame source, in priority order:
    - pend_v: act<=pend. If cap_strobe in the same cycle, pend<=in_words and pend_v stays 1; otherwise pend_v<=0. Stay in SEND.
    - else cap_strobe: act<=in_words. Stay in SEND.
    - else go to IDLE.
- cap_strobe in SEND, not coinciding with the idx==7 handshake:
  - If !pend_v: pend<=in_words, pend_v<=1.
  - If pend_v: capture discarded, drop_cnt++ (saturating). The older pending data is kept.
- act is never modified mid-frame. out_data is stable while out_valid && !out_ready.

## Timing
- Reset (rst high at a posedge) forces: state=IDLE, idx=0, pend_v=0, signature=0, frame_cnt=0, drop_cnt=0, out_valid=0, out_last=0, frame_done=0, out_data=0, out_idx=0.
- Reset mid-frame abandons both the frame and the pending slot. No partial-frame counter update.
- Reset wins over a simultaneous cap_strobe.
- Latency: cap_strobe in IDLE at cycle N gives out_valid=1 with word 0 at cycle N+1.
- Throughput: with out_ready held high, 8 words in 8 consecutive cycles. Back-to-back frames have no bubble.
- frame_cnt and signature are visible the cycle after the final handshake, aligned with frame_done.
- out_valid never drops without a handshake, except on reset.

## Test plan
- Reset, then in_words = words 0..7 holding 0..7, cap_strobe at N, out_ready=1 -> words 0..7 on cycles N+1..N+8, out_last at N+8, frame_done at N+9, frame_cnt=1. signature equals the golden model; the first step gives 0 after word 0 and 0 rotated + (1^1)=0 after word 1.
- Same frame with out_ready toggling 1,0,0,1,... -> out_data holds during stalls, exactly 8 handshakes, same final signature as the first scenario.
- Three strobes during a frame (A active, B and C arrive) -> B is sent next with no bubble, C is dropped, drop_cnt=1, frame_cnt=2 after B.
- cap_strobe exactly on the word-7 handshake with pend_v=0 -> new frame starts next cycle with idx=0, pend_v stays 0, drop_cnt=0.
- Force drop_cnt to all-ones via repeated overflow (or DROP_W=2, four excess drops) -> stays at 3.
- rst asserted at word index 4 with pend_v=1 -> next cycle out_valid=0 and all counters 0. A following single strobe produces a clean frame starting at idx 0.
